// File: rtl/three_way_block_packer.sv
// ---------------------------------------------------------------------------
// three_way_block_packer
//
// Packs a stream of 32-bit AXI-Stream words into 96-bit blocks for a 96-bit
// cipher pipeline.
//
// Word order is little-endian by word:
//   - first word  -> bits [31:0]
//   - second word -> bits [63:32]
//   - third word  -> bits [95:64]
//
// A block is closed by either the third word or a word carrying tlast. In a
// short final block, the slots above the last real word are filled with
// PAD_WORD, and m_axis_tkeep marks which words are real.
//
// The output register is a single entry. The slave side is ready whenever
// that entry is empty or is being drained in the same cycle. This gives one
// word per cycle while m_axis_tready stays high.
//
// Parameters
//   PAD_WORD       fill value for unused words of a short final block
//
// Ports
//   clk            sole clock, rising edge
//   rst            synchronous active-high reset
//   s_axis_tdata   input word
//   s_axis_tvalid  input word valid
//   s_axis_tlast   last word of message
//   s_axis_tready  packer accepts input word (combinational)
//   m_axis_tdata   assembled 96-bit block
//   m_axis_tvalid  block valid
//   m_axis_tlast   block contains the message's last word
//   m_axis_tkeep   per-word valid flags, bit k covers tdata[32k+31:32k]
//   m_axis_tready  downstream accepts block
//   blk_count      count of blocks transferred on the master side (wraps)
// ---------------------------------------------------------------------------
module three_way_block_packer #(
  parameter logic [31:0] PAD_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [95:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  output logic [2:0]  m_axis_tkeep,
  input  logic        m_axis_tready,
  output logic [15:0] blk_count
);

  // Accumulator state: number of words held so far and the words themselves.
  logic [1:0]  cnt_q,   cnt_d;
  logic [63:0] acc_q,   acc_d;

  // Output block register.
  logic [95:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q,  tlast_d;
  logic [2:0]  tkeep_q,  tkeep_d;
  logic [15:0] blk_q,    blk_d;

  logic in_xfer;
  logic out_xfer;
  logic complete;

  // Build the outgoing block from the stored words plus the completing word.
  // Slots above the completing word take PAD_WORD, never old accumulator
  // contents, so data from an earlier block cannot leak into a short block.
  function automatic logic [95:0] assemble_block(
    input logic [1:0]  cnt,
    input logic [63:0] acc,
    input logic [31:0] word
  );
    logic [95:0] blk;
    case (cnt)
      2'd0:    blk = {PAD_WORD, PAD_WORD, word};
      2'd1:    blk = {PAD_WORD, word, acc[31:0]};
      default: blk = {word, acc[63:32], acc[31:0]};
    endcase
    return blk;
  endfunction

  // tkeep is a thermometer code of the number of real words in the block.
  function automatic logic [2:0] keep_for(input logic [1:0] cnt);
    logic [2:0] keep;
    case (cnt)
      2'd0:    keep = 3'b001;
      2'd1:    keep = 3'b011;
      default: keep = 3'b111;
    endcase
    return keep;
  endfunction

  // The slave may push whenever the output slot is free, or is being freed
  // this cycle. This path deliberately ignores s_axis_tvalid.
  assign s_axis_tready = !tvalid_q || m_axis_tready;

  assign in_xfer  = s_axis_tvalid && s_axis_tready;
  assign out_xfer = tvalid_q && m_axis_tready;

  // cnt_q[1] also covers the unreachable value 3, so the FSM cannot stick.
  assign complete = in_xfer && (s_axis_tlast || cnt_q[1]);

  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    tkeep_d  = tkeep_q;
    blk_d    = blk_q;

    if (out_xfer) begin
      tvalid_d = 1'b0;
      blk_d    = blk_q + 16'd1;
    end

    // A completion in the same cycle as a drain overrides the clear above.
    // The new block then replaces the old one with no bubble.
    if (in_xfer) begin
      if (complete) begin
        tdata_d  = assemble_block(cnt_q, acc_q, s_axis_tdata);
        tkeep_d  = keep_for(cnt_q);
        tlast_d  = s_axis_tlast;
        tvalid_d = 1'b1;
        cnt_d    = 2'd0;
        acc_d    = '0;
      end else begin
        if (cnt_q == 2'd0) begin
          acc_d[31:0] = s_axis_tdata;
        end else begin
          acc_d[63:32] = s_axis_tdata;
        end
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  // ---- stage boundary: accumulator and output block registers ----
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= 2'd0;
      acc_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tkeep_q  <= 3'b000;
      blk_q    <= 16'd0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tkeep_q  <= tkeep_d;
      blk_q    <= blk_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tkeep  = tkeep_q;
  assign blk_count     = blk_q;

endmodule

// File: tb/tb_three_way_block_packer.sv
module tb_three_way_block_packer;

  localparam logic [31:0] PAD = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic        s_axis_tready;
  logic [95:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic [2:0]  m_axis_tkeep;
  logic        m_axis_tready;
  logic [15:0] blk_count;

  three_way_block_packer #(.PAD_WORD(PAD)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tready (m_axis_tready),
    .blk_count     (blk_count)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: words of the message collected so far, and the blocks
  // waiting on the master side.
  typedef struct {
    logic [95:0] d;
    logic [2:0]  k;
    logic        l;
  } blk_t;

  blk_t        mq[$];
  logic [31:0] mw[$];
  logic [15:0] mblk = 16'd0;
  logic        obs_sready;
  logic        exp_sready;

  // Apply one cycle of stimulus and advance the model. Called just after a
  // falling edge. It returns just after the next falling edge, with the DUT
  // outputs settled for checking.
  task automatic cycle(input bit r, input bit v, input logic [31:0] d,
                       input bit l, input bit mr);
    bit   mv;
    blk_t b;
    rst           = r;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    m_axis_tready = mr;
    #1;
    obs_sready = s_axis_tready;
    mv         = (mq.size() != 0);
    exp_sready = !mv || mr;
    if (r) begin
      mq.delete();
      mw.delete();
      mblk = 16'd0;
    end else begin
      if (mv && mr) begin
        void'(mq.pop_front());
        mblk = mblk + 16'd1;
      end
      if (v && exp_sready) begin
        mw.push_back(d);
        if (l || mw.size() == 3) begin
          b.d = {PAD, PAD, PAD};
          for (int i = 0; i < mw.size(); i++) b.d[32*i +: 32] = mw[i];
          b.k = (mw.size() == 1) ? 3'b001 : (mw.size() == 2) ? 3'b011 : 3'b111;
          b.l = l;
          mq.push_back(b);
          mw.delete();
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1, 1, 32'hFFFF_FFFF, 1, 0);
    cycle(1, 1, 32'hFFFF_FFFF, 1, 0);
    tests_run++;
    if (obs_sready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_sready got=%b exp=1", obs_sready);
    end
    tests_run++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tkeep} !== 5'b0
        || m_axis_tdata !== 96'd0 || blk_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs got v=%b l=%b k=%b d=%h c=%h exp all zero",
               m_axis_tvalid, m_axis_tlast, m_axis_tkeep, m_axis_tdata, blk_count);
    end
    cycle(0, 0, 0, 0, 0);
    tests_run++;
    if (obs_sready !== 1'b1 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL post_reset got sready=%b tvalid=%b exp 1/0", obs_sready, m_axis_tvalid);
    end
  endtask

  task automatic test_full_block();
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 32'h1111_1111, 0, 1);
    cycle(0, 1, 32'h2222_2222, 0, 1);
    cycle(0, 1, 32'h3333_3333, 1, 1);
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 96'h333333332222222211111111
        || m_axis_tkeep !== 3'b111 || m_axis_tlast !== 1'b1) begin
      tests_failed++;
      $display("FAIL full_block got v=%b d=%h k=%b l=%b exp 1/333333332222222211111111/111/1",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast);
    end
    // The old block drains in the same cycle a one-word block completes.
    cycle(0, 1, 32'h4444_4444, 1, 1);
    tests_run++;
    if (blk_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL full_block_count got=%0d exp=1", blk_count);
    end
    tests_run++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== {PAD, PAD, 32'h4444_4444}
        || m_axis_tkeep !== 3'b001) begin
      tests_failed++;
      $display("FAIL no_stale got v=%b d=%h k=%b exp 1/%h/001",
               m_axis_tvalid, m_axis_tdata, m_axis_tkeep, {PAD, PAD, 32'h4444_4444});
    end
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || blk_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL drain got v=%b c=%0d exp 0/2", m_axis_tvalid, blk_count);
    end
  endtask

  task automatic test_single_word();
    cycle(0, 1, 32'hDEAD_BEEF, 1, 0);
    tests_run++;
    if (m_axis_tdata !== 96'hA5A5A5A5A5A5A5A5DEADBEEF || m_axis_tkeep !== 3'b001
        || m_axis_tlast !== 1'b1 || m_axis_tvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_word got d=%h k=%b l=%b v=%b exp A5A5A5A5A5A5A5A5DEADBEEF/001/1/1",
               m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tvalid);
    end
    cycle(0, 1, 32'h0101_0101, 0, 1);
    cycle(0, 1, 32'h0202_0202, 1, 1);
    tests_run++;
    if (m_axis_tdata !== {PAD, 32'h0202_0202, 32'h0101_0101} || m_axis_tkeep !== 3'b011) begin
      tests_failed++;
      $display("FAIL two_word got d=%h k=%b exp %h/011",
               m_axis_tdata, m_axis_tkeep, {PAD, 32'h0202_0202, 32'h0101_0101});
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_backpressure();
    cycle(1, 0, 0, 0, 0);
    cycle(0, 1, 32'hA1A1_A1A1, 0, 0);
    cycle(0, 1, 32'hB2B2_B2B2, 0, 0);
    cycle(0, 1, 32'hC3C3_C3C3, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 32'hEEEE_0000 + i, 1, 0);
      tests_run++;
      if (obs_sready !== 1'b0 || m_axis_tvalid !== 1'b1
          || m_axis_tdata !== 96'hC3C3C3C3B2B2B2B2A1A1A1A1 || m_axis_tkeep !== 3'b111) begin
        tests_failed++;
        $display("FAIL stall%0d got sready=%b v=%b d=%h k=%b exp 0/1/C3C3C3C3B2B2B2B2A1A1A1A1/111",
                 i, obs_sready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep);
      end
    end
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (obs_sready !== 1'b1 || m_axis_tvalid !== 1'b0 || blk_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL release got sready=%b v=%b c=%0d exp 1/0/1", obs_sready, m_axis_tvalid, blk_count);
    end
    cycle(0, 1, 32'h7777_7777, 1, 1);
    tests_run++;
    if (m_axis_tdata !== {PAD, PAD, 32'h7777_7777} || m_axis_tkeep !== 3'b001) begin
      tests_failed++;
      $display("FAIL after_stall got d=%h k=%b exp %h/001", m_axis_tdata, m_axis_tkeep,
               {PAD, PAD, 32'h7777_7777});
    end
    cycle(0, 0, 0, 0, 1);
  endtask

  task automatic test_stream();
    int nvalid = 0;
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 30; i++) begin
      cycle(0, 1, 32'h1000 + i, (i == 29), 1);
      tests_run++;
      if (obs_sready !== 1'b1 || m_axis_tvalid !== (i % 3 == 2)) begin
        tests_failed++;
        $display("FAIL stream%0d got sready=%b v=%b exp 1/%b", i, obs_sready, m_axis_tvalid, (i % 3 == 2));
      end
      if (m_axis_tvalid === 1'b1) nvalid++;
    end
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (nvalid != 10 || blk_count !== 16'd10 || m_axis_tvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_count got blocks=%0d c=%0d v=%b exp 10/10/0", nvalid, blk_count, m_axis_tvalid);
    end
  endtask

  task automatic test_mid_reset();
    cycle(1, 0, 0, 0, 1);
    cycle(0, 1, 32'hAAAA_AAAA, 0, 1);
    cycle(0, 1, 32'hBBBB_BBBB, 0, 1);
    cycle(1, 1, 32'hCCCC_CCCC, 1, 1);
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || blk_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL mid_reset got v=%b c=%0d exp 0/0", m_axis_tvalid, blk_count);
    end
    cycle(0, 1, 32'h1, 0, 1);
    cycle(0, 1, 32'h2, 0, 1);
    cycle(0, 1, 32'h3, 1, 1);
    tests_run++;
    if (m_axis_tdata !== 96'h000000030000000200000001 || m_axis_tkeep !== 3'b111) begin
      tests_failed++;
      $display("FAIL after_reset got d=%h k=%b exp 000000030000000200000001/111", m_axis_tdata, m_axis_tkeep);
    end
    // Reset must win over a pending block that is being held by backpressure.
    cycle(0, 0, 0, 0, 0);
    cycle(1, 1, 32'h9, 1, 1);
    tests_run++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 96'd0 || m_axis_tkeep !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_priority got v=%b d=%h k=%b exp 0/0/000", m_axis_tvalid, m_axis_tdata, m_axis_tkeep);
    end
  endtask

  task automatic test_random();
    bit r, v, l, mr;
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      v  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 3) == 0);
      mr = ($urandom_range(0, 3) != 0);
      cycle(r, v, $urandom, l, mr);
      tests_run++;
      if (obs_sready !== exp_sready) begin
        tests_failed++;
        $display("FAIL rnd_sready cyc=%0d got=%b exp=%b", i, obs_sready, exp_sready);
      end
      tests_run++;
      if (m_axis_tvalid !== (mq.size() != 0) || blk_count !== mblk) begin
        tests_failed++;
        $display("FAIL rnd_state cyc=%0d got v=%b c=%0d exp v=%b c=%0d",
                 i, m_axis_tvalid, blk_count, (mq.size() != 0), mblk);
      end
      if (mq.size() != 0) begin
        tests_run++;
        if (m_axis_tdata !== mq[0].d || m_axis_tkeep !== mq[0].k || m_axis_tlast !== mq[0].l) begin
          tests_failed++;
          $display("FAIL rnd_block cyc=%0d got d=%h k=%b l=%b exp d=%h k=%b l=%b",
                   i, m_axis_tdata, m_axis_tkeep, m_axis_tlast, mq[0].d, mq[0].k, mq[0].l);
        end
      end
    end
  endtask

  task automatic test_count_wrap();
    cycle(1, 0, 0, 0, 1);
    for (int i = 0; i < 65535; i++) cycle(0, 1, i, 1, 1);
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (blk_count !== 16'hFFFF) begin
      tests_failed++;
      $display("FAIL count_preload got=%h exp=FFFF", blk_count);
    end
    cycle(0, 1, 32'h5555_5555, 1, 1);
    cycle(0, 0, 0, 0, 1);
    tests_run++;
    if (blk_count !== 16'h0000 || blk_count !== mblk) begin
      tests_failed++;
      $display("FAIL count_wrap got=%h exp=0000", blk_count);
    end
  endtask

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b0;
    @(negedge clk);
    test_reset();
    test_full_block();
    test_single_word();
    test_backpressure();
    test_stream();
    test_mid_reset();
    test_random();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
